serial_tx_arbiter: RTL

SERIAL_TX_ARBITER -- requirements
Module: serial_tx_arbiter

---
 rtl/serial_tx_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among eight byte requesters.
// Each owner is granted, started, drained and acked before the next arbitration.
module serial_tx_arbiter #(
   parameter int DATA_W = 8,
   parameter int NREQ   = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] data_in,
   input  logic                   tx_busy,
   output logic [NREQ-1:0]        grant,
   output logic [2:0]             cur_idx,
   output logic [DATA_W-1:0]      tx_data,
   output logic                   tx_start,
   output logic [NREQ-1:0]        ack
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, DRAIN} state_t;

   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   state_t            r_state;
   logic [2:0]        r_ptr;
   logic [2:0]        r_cur_idx;
   logic [NREQ-1:0]   r_grant;
   logic [DATA_W-1:0] r_tx_data;
   logic              r_tx_start;
   logic [NREQ-1:0]   r_ack;

   logic [2:0]        w_win;
   logic              w_found;

   // First set request at or above the pointer, wrapping 7 -> 0.
   always_comb begin
      w_win   = r_ptr;
      w_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!w_found && req[r_ptr + 3'(k)]) begin
            w_win   = r_ptr + 3'(k);
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_ptr      <= '0;
         r_cur_idx  <= '0;
         r_grant    <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_ack      <= '0;
      end else begin
         r_tx_start <= 1'b0;
         r_ack      <= '0;
         case (r_state)
            // The ack cycle is not an arbitration slot: the finished owner
            // still shows req until it has seen its ack.
            IDLE: begin
               if (r_ack == '0 && w_found) begin
                  r_cur_idx <= w_win;
                  r_grant   <= ONE << w_win;
                  r_tx_data <= data_in[w_win*DATA_W +: DATA_W];
                  r_state   <= LOAD;
               end
            end
            LOAD: begin
               if (!tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_state    <= SEND;
               end
            end
            SEND: begin
               if (tx_busy)
                  r_state <= DRAIN;
            end
            DRAIN: begin
               if (!tx_busy) begin
                  r_ack   <= ONE << r_cur_idx;
                  r_ptr   <= r_cur_idx + 3'd1;
                  r_grant <= '0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign grant    = r_grant;
   assign cur_idx  = r_cur_idx;
   assign tx_data  = r_tx_data;
   assign tx_start = r_tx_start;
   assign ack      = r_ack;

endmodule
